// File: rtl/tdm_demux.sv
// tdm_demux: splits a time-division-multiplexed sample stream into
// full-width frames of NCH slots, each WIDTH bits wide.
//
// A frame starts on a din_valid sample flagged by frame_sync (slot 0).
// Slots 1..NCH-1 follow on later valid samples, and idle gaps may occur
// between them. When the last slot arrives, the whole frame is presented
// on dout at that same clock edge, and dout_valid pulses for one cycle.
//
// Framing errors pulse sync_err for one cycle:
//   - a sync that arrives before a frame is complete restarts the frame;
//   - a missing sync where slot 0 was expected drops back to hunting.
//
// Optional feature: define TDM_DEMUX_FRAME_CNT_EN to add a 16-bit frame_cnt
// output. It counts completed frames.
module tdm_demux #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [NCH*WIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic                 locked,
  output logic                 sync_err
`ifdef TDM_DEMUX_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_cnt
`endif
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(NCH - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Only slots 0..NCH-2 need storage. The last slot goes straight from din
  // into dout at the edge where it arrives, which is what gives zero added
  // latency and no bubble between frames.
  logic [WIDTH-1:0] shadow [NCH-1];

  logic                 store_en;
  logic [CW-1:0]        store_idx;
  logic                 frame_done;
  logic                 err_set;
  logic [NCH*WIDTH-1:0] frame_word;

  // State register and slot counter; reset drops back to hunting for sync
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and datapath control, decided only on cycles carrying a sample
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    store_en   = 1'b0;
    store_idx  = cnt;
    frame_done = 1'b0;
    err_set    = 1'b0;

    if (din_valid) begin
      unique case (state)
        HUNT: begin
          if (frame_sync) begin
            store_en   = 1'b1;
            store_idx  = '0;
            cnt_next   = CW'(1);
            state_next = LOCKED;
          end
        end

        LOCKED: begin
          if (frame_sync) begin
            // A sync that arrives mid-frame is honoured, but the
            // partial frame is abandoned and the error is flagged.
            err_set   = (cnt != '0);
            store_en  = 1'b1;
            store_idx = '0;
            cnt_next  = CW'(1);
          end else if (cnt == '0) begin
            // Slot 0 was expected but no sync was marked: lock is lost.
            err_set    = 1'b1;
            state_next = HUNT;
          end else if (cnt == LAST_SLOT) begin
            frame_done = 1'b1;
            cnt_next   = '0;
          end else begin
            store_en = 1'b1;
            cnt_next = cnt + CW'(1);
          end
        end

        default: begin
          state_next = HUNT;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Shadow slots collect the first NCH-1 samples of the frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NCH - 1; k++) begin
        shadow[k] <= '0;
      end
    end else if (store_en) begin
      shadow[store_idx] <= din;
    end
  end

  // Frame to publish: the stored slots plus the last slot taken live from din
  always_comb begin
    frame_word = '0;
    for (int k = 0; k < NCH - 1; k++) begin
      frame_word[k*WIDTH +: WIDTH] = shadow[k];
    end
    frame_word[(NCH-1)*WIDTH +: WIDTH] = din;
  end

  // Registered outputs: dout holds between frames, and the flags are single-cycle pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      dout_valid <= frame_done;
      sync_err   <= err_set;
      if (frame_done) begin
        dout <= frame_word;
      end
    end
  end

  assign locked = (state == LOCKED);

`ifdef TDM_DEMUX_FRAME_CNT_EN
  // Completed-frame counter, advancing in step with each dout_valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (frame_done) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Testbench for tdm_demux (WIDTH=8, NCH=4).
// The bench has two parts:
//   - A directed vector table with hand-derived expected outputs.
//   - A randomized run checked against a frame-level reference model that
//     uses a queue of collected samples.
module tb_tdm_demux;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;

  logic                 clk;
  logic                 rst;
  logic [WIDTH-1:0]     din;
  logic                 din_valid;
  logic                 frame_sync;
  logic [NCH*WIDTH-1:0] dout;
  logic                 dout_valid;
  logic                 locked;
  logic                 sync_err;
`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [15:0]          frame_cnt;
  logic [15:0]          exp_fcnt;
`endif

  int n_compared;
  int n_mismatched;

  tdm_demux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .locked     (locked),
    .sync_err   (sync_err)
`ifdef TDM_DEMUX_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  // Free-running clock with a 10-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic                 rst;
    logic                 vld;
    logic                 sync;
    logic [WIDTH-1:0]     din;
    logic [NCH*WIDTH-1:0] e_dout;
    logic                 e_dv;
    logic                 e_lock;
    logic                 e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic r, input logic v, input logic s,
                                 input logic [WIDTH-1:0] d,
                                 input logic [NCH*WIDTH-1:0] ed,
                                 input logic edv, input logic el, input logic ee);
    vec_t t;
    t.rst    = r;
    t.vld    = v;
    t.sync   = s;
    t.din    = d;
    t.e_dout = ed;
    t.e_dv   = edv;
    t.e_lock = el;
    t.e_err  = ee;
    vecs.push_back(t);
  endfunction

  // Drive the inputs on the falling edge, then return just after the next rising edge
  task automatic applyStimulus(input logic r, input logic v, input logic s,
                               input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst        = r;
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int id,
                             input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s @%0d: got %h, expected %h", name, id, act, exp);
    end
  endtask

  // Frame-level reference model state
  logic [WIDTH-1:0]     m_q[$];
  bit                   m_locked;
  logic [NCH*WIDTH-1:0] m_dout;
  bit                   m_dv;
  bit                   m_err;
  int                   m_fcnt;

  // Advance the model by one clock edge with the given inputs
  function automatic void modelStep(input logic r, input logic v, input logic s,
                                    input logic [WIDTH-1:0] d);
    m_dv  = 0;
    m_err = 0;
    if (r) begin
      m_q.delete();
      m_locked = 0;
      m_dout   = '0;
      m_fcnt   = 0;
    end else if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_q.delete();
          m_q.push_back(d);
          m_locked = 1;
        end
      end else if (s) begin
        if (m_q.size() != 0) m_err = 1;
        m_q.delete();
        m_q.push_back(d);
      end else if (m_q.size() == 0) begin
        m_err    = 1;
        m_locked = 0;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == NCH) begin
          for (int k = 0; k < NCH; k++) m_dout[k*WIDTH +: WIDTH] = m_q[k];
          m_dv = 1;
          m_fcnt = (m_fcnt + 1) % 65536;
          m_q.delete();
        end
      end
    end
  endfunction

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst          = 1'b1;
    din_valid    = 1'b0;
    frame_sync   = 1'b0;
    din          = '0;
`ifdef TDM_DEMUX_FRAME_CNT_EN
    exp_fcnt     = '0;
`endif

    // Reset
    addVec(1, 0, 0, 8'h00, 32'h0, 0, 0, 0);
    // Basic frame: lock on sync, publish after the fourth slot
    addVec(0, 1, 1, 8'h11, 32'h0,        0, 1, 0);
    addVec(0, 1, 0, 8'h22, 32'h0,        0, 1, 0);
    addVec(0, 1, 0, 8'h33, 32'h0,        0, 1, 0);
    addVec(0, 1, 0, 8'h44, 32'h44332211, 1, 1, 0);
    // Back-to-back frames with no gaps
    addVec(0, 1, 1, 8'h01, 32'h44332211, 0, 1, 0);
    addVec(0, 1, 0, 8'h02, 32'h44332211, 0, 1, 0);
    addVec(0, 1, 0, 8'h03, 32'h44332211, 0, 1, 0);
    addVec(0, 1, 0, 8'h04, 32'h04030201, 1, 1, 0);
    addVec(0, 1, 1, 8'h05, 32'h04030201, 0, 1, 0);
    addVec(0, 1, 0, 8'h06, 32'h04030201, 0, 1, 0);
    addVec(0, 1, 0, 8'h07, 32'h04030201, 0, 1, 0);
    addVec(0, 1, 0, 8'h08, 32'h08070605, 1, 1, 0);
    // Three-cycle gaps between slots; a sync without valid is ignored
    addVec(0, 1, 1, 8'h11, 32'h08070605, 0, 1, 0);
    for (int g = 0; g < 3; g++) addVec(0, 0, (g == 1), 8'hEE, 32'h08070605, 0, 1, 0);
    addVec(0, 1, 0, 8'h22, 32'h08070605, 0, 1, 0);
    for (int g = 0; g < 3; g++) addVec(0, 0, 1, 8'hDD, 32'h08070605, 0, 1, 0);
    addVec(0, 1, 0, 8'h33, 32'h08070605, 0, 1, 0);
    for (int g = 0; g < 3; g++) addVec(0, 0, 0, 8'hCC, 32'h08070605, 0, 1, 0);
    addVec(0, 1, 0, 8'h44, 32'h44332211, 1, 1, 0);
    addVec(0, 0, 0, 8'h00, 32'h44332211, 0, 1, 0);
    // Early sync at cnt=2 abandons the A frame
    addVec(0, 1, 1, 8'hA0, 32'h44332211, 0, 1, 0);
    addVec(0, 1, 0, 8'hA1, 32'h44332211, 0, 1, 0);
    addVec(0, 1, 1, 8'hB0, 32'h44332211, 0, 1, 1);
    addVec(0, 1, 0, 8'hB1, 32'h44332211, 0, 1, 0);
    addVec(0, 1, 0, 8'hB2, 32'h44332211, 0, 1, 0);
    addVec(0, 1, 0, 8'hB3, 32'hB3B2B1B0, 1, 1, 0);
    // Missing sync loses lock; further unsynced samples are ignored silently
    addVec(0, 1, 0, 8'h55, 32'hB3B2B1B0, 0, 0, 1);
    addVec(0, 1, 0, 8'h66, 32'hB3B2B1B0, 0, 0, 0);
    addVec(0, 1, 0, 8'h77, 32'hB3B2B1B0, 0, 0, 0);
    // Reset mid-frame, then reacquire lock only through a sync
    addVec(0, 1, 1, 8'hC0, 32'hB3B2B1B0, 0, 1, 0);
    addVec(0, 1, 0, 8'hC1, 32'hB3B2B1B0, 0, 1, 0);
    addVec(1, 1, 0, 8'hC2, 32'h0,        0, 0, 0);
    addVec(0, 1, 0, 8'hC3, 32'h0,        0, 0, 0);
    addVec(0, 1, 1, 8'hD0, 32'h0,        0, 1, 0);
    addVec(0, 1, 0, 8'hD1, 32'h0,        0, 1, 0);
    addVec(0, 1, 0, 8'hD2, 32'h0,        0, 1, 0);
    addVec(0, 1, 0, 8'hD3, 32'hD3D2D1D0, 1, 1, 0);
    addVec(0, 0, 0, 8'h00, 32'hD3D2D1D0, 0, 1, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].sync, vecs[i].din);
      checkOutput("dout",       i, 64'(dout),       64'(vecs[i].e_dout));
      checkOutput("dout_valid", i, 64'(dout_valid), 64'(vecs[i].e_dv));
      checkOutput("locked",     i, 64'(locked),     64'(vecs[i].e_lock));
      checkOutput("sync_err",   i, 64'(sync_err),   64'(vecs[i].e_err));
`ifdef TDM_DEMUX_FRAME_CNT_EN
      if (vecs[i].rst) exp_fcnt = '0;
      else if (vecs[i].e_dv) exp_fcnt = exp_fcnt + 16'd1;
      checkOutput("frame_cnt", i, 64'(frame_cnt), 64'(exp_fcnt));
`endif
    end

    // Randomized run against the reference model, starting from reset
    modelStep(1, 0, 0, '0);
    applyStimulus(1, 0, 0, '0);
    for (int c = 0; c < 2000; c++) begin
      logic r, v, s;
      logic [WIDTH-1:0] d;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 99) < 70);
      if (m_q.size() == 0) s = ($urandom_range(0, 99) < 85);
      else                 s = ($urandom_range(0, 99) < 6);
      d = WIDTH'($urandom);
      modelStep(r, v, s, d);
      applyStimulus(r, v, s, d);
      checkOutput("rnd_dout",       c, 64'(dout),       64'(m_dout));
      checkOutput("rnd_dout_valid", c, 64'(dout_valid), 64'(m_dv));
      checkOutput("rnd_locked",     c, 64'(locked),     64'(m_locked));
      checkOutput("rnd_sync_err",   c, 64'(sync_err),   64'(m_err));
`ifdef TDM_DEMUX_FRAME_CNT_EN
      checkOutput("rnd_frame_cnt",  c, 64'(frame_cnt),  64'(m_fcnt));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 Parameter WIDTH, default 8: bits per TDM slot.
REQ-002 Parameter NCH, default 4: slots per frame (2..16).
REQ-003 clk  input  1  single clock; all logic updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 din  input  WIDTH  time-multiplexed slot data.
REQ-006 din_valid  input  1  din carries a slot this cycle; no backpressure.
REQ-007 frame_sync  input  1  qualified by din_valid; marks the slot-0 sample.
REQ-008 dout  output  NCH*WIDTH  last complete frame; slot k at bits [k*WIDTH +: WIDTH].
REQ-009 dout_valid  output  1  one-cycle pulse when dout is updated.
REQ-010 locked  output  1  high while the state machine is in LOCKED.
REQ-011 sync_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-012 The block SHALL be a two-state FSM (HUNT, LOCKED) with a slot counter cnt of $clog2(NCH) bits and an NCH*WIDTH shadow register.
REQ-013 HUNT: samples with din_valid=1 and frame_sync=0 SHALL be discarded with no error.
REQ-014 HUNT: din_valid=1 and frame_sync=1 SHALL store din in shadow slot 0, set cnt=1, and enter LOCKED.
REQ-015 LOCKED: din_valid=1 and frame_sync=0 with cnt!=0 SHALL store din in shadow slot cnt and increment cnt.
REQ-016 When slot NCH-1 is stored, dout SHALL load the full frame (shadow slots 0..NCH-2 plus the current din) at that same edge, dout_valid SHALL be 1 for exactly that following cycle, and cnt SHALL wrap to 0.
REQ-017 LOCKED: din_valid=1 and frame_sync=1 with cnt=0 SHALL start a new frame as in REQ-014, with no error.
REQ-018 LOCKED: frame_sync=1 with cnt!=0 (early sync) SHALL pulse sync_err, discard the partial frame with no dout_valid, store din as slot 0, set cnt=1, and remain LOCKED.
REQ-019 LOCKED: din_valid=1 and frame_sync=0 with cnt=0 (missing sync) SHALL pulse sync_err, discard the sample, and enter HUNT.
REQ-020 din_valid=0 SHALL hold the state, cnt and shadow; frame_sync without din_valid SHALL be ignored; idle gaps SHALL NOT time out.
REQ-021 dout SHALL hold its value between dout_valid pulses.
REQ-022 Input-to-output latency: the sample of the last slot SHALL appear on dout exactly one clock edge after it is presented, with no pipeline bubble between consecutive frames.

Reset
REQ-023 A rst=1 sampled at a clock edge SHALL force HUNT, cnt=0, shadow=0, dout=0, dout_valid=0, locked=0 and sync_err=0, overriding all other inputs.
REQ-024 Reset mid-frame SHALL discard the partial frame with no dout_valid; lock SHALL be reacquired only via REQ-014.

Configuration
REQ-025 Macro TDM_DEMUX_FRAME_CNT_EN defined: the block SHALL add output frame_cnt (16 bits), which is reset to 0 and increments, wrapping at 16'hFFFF, on each dout_valid pulse.
REQ-026 Macro TDM_DEMUX_FRAME_CNT_EN undefined: the port and the counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 Reset, then din=0x11,0x22,0x33,0x44 with valid=1 and sync on the first sample -> locked=1 after the first edge; dout=0x44332211 and a single dout_valid pulse after the fourth edge.
REQ-028 Two back-to-back frames with no gaps (0x01..0x04, then 0x05..0x08) -> two dout_valid pulses 4 cycles apart; final dout=0x08070605; sync_err stays 0.
REQ-029 Frame with din_valid=0 gaps of 3 cycles between slots -> the same dout as the gap-free case; dout_valid pulses only after the last slot.
REQ-030 Sync at cnt=2 (0xA0,0xA1, then sync 0xB0,0xB1,0xB2,0xB3) -> one sync_err pulse; no dout_valid for the A frame; dout=0xB3B2B1B0.
REQ-031 After a complete frame, valid without sync (0x55) -> sync_err pulse, locked=0, dout unchanged; then 0x66,0x77 without sync are ignored with no sync_err.
REQ-032 rst=1 asserted for one cycle after 2 of 4 slots -> all outputs 0 and locked=0; with the macro enabled, frame_cnt=0, then becomes 1 after the next full frame.
